// File: rtl/bcd_timekeeper.sv
// Real-time clock: prescaled 1 Hz BCD hh:mm:ss counter with load,
// 12/24 h display mapping and registered event strobes.
module bcd_timekeeper #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned PRESCALE_W = 32
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [3:0] ld_h1,
    input  logic [3:0] ld_h0,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_m0,
    input  logic [3:0] ld_s1,
    input  logic [3:0] ld_s0,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       pm,
    output logic       tick_1hz,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       load_err
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(CLK_HZ - 1);
    localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
    logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
    logic tick_q, min_q, hour_q, day_q, err_q;
    logic tick_d, min_d, hour_d, day_d, err_d;
    logic step, ld_ok, ld_go, sec_wrap, min_wrap, hr_wrap;

    always_comb begin
        step     = en && (presc_q == LAST);
        sec_wrap = (s1_q == 4'd5) && (s0_q == 4'd9);
        min_wrap = (m1_q == 4'd5) && (m0_q == 4'd9);
        hr_wrap  = (h1_q == 4'd2) && (h0_q == 4'd3);
        ld_ok    = (ld_h1 <= 4'd2) && (ld_h0 <= 4'd9)
                && !((ld_h1 == 4'd2) && (ld_h0 > 4'd3))
                && (ld_m1 <= 4'd5) && (ld_m0 <= 4'd9)
                && (ld_s1 <= 4'd5) && (ld_s0 <= 4'd9);
        ld_go    = load && ld_ok;
        presc_d  = presc_q;
        h1_d     = h1_q;
        h0_d     = h0_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        s1_d     = s1_q;
        s0_d     = s0_q;
        if (ld_go) begin
            presc_d = '0;
            h1_d    = ld_h1;
            h0_d    = ld_h0;
            m1_d    = ld_m1;
            m0_d    = ld_m0;
            s1_d    = ld_s1;
            s0_d    = ld_s0;
        end else begin
            if (en) presc_d = step ? '0 : presc_q + ONE;
            if (step) begin
                s0_d = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
                if (s0_q == 4'd9) s1_d = sec_wrap ? 4'd0 : s1_q + 4'd1;
                if (sec_wrap) m0_d = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
                if (sec_wrap && (m0_q == 4'd9))
                    m1_d = min_wrap ? 4'd0 : m1_q + 4'd1;
                if (sec_wrap && min_wrap) begin
                    if (hr_wrap) begin
                        h1_d = 4'd0;
                        h0_d = 4'd0;
                    end else if (h0_q == 4'd9) begin
                        h1_d = h1_q + 4'd1;
                        h0_d = 4'd0;
                    end else begin
                        h0_d = h0_q + 4'd1;
                    end
                end
            end
        end
        tick_d = step && !ld_go;
        min_d  = tick_d && sec_wrap;
        hour_d = min_d && min_wrap;
        day_d  = hour_d && hr_wrap;
        // a held load line must not stretch the error strobe
        err_d  = load && !ld_ok && !err_q;
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            presc_q <= '0;
            h1_q    <= '0;
            h0_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            s1_q    <= '0;
            s0_q    <= '0;
            tick_q  <= 1'b0;
            min_q   <= 1'b0;
            hour_q  <= 1'b0;
            day_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            tick_q  <= tick_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        h1 = h1_q;
        h0 = h0_q;
        if (mode_12h) begin
            unique case (1'b1)
                (h1_q == 4'd0) && (h0_q == 4'd0): begin
                    h1 = 4'd1;
                    h0 = 4'd2;
                end
                (h1_q == 4'd1) && (h0_q >= 4'd3): begin
                    h1 = 4'd0;
                    h0 = h0_q - 4'd2;
                end
                (h1_q == 4'd2) && (h0_q <= 4'd1): begin
                    h1 = 4'd0;
                    h0 = h0_q + 4'd8;
                end
                (h1_q == 4'd2) && (h0_q >= 4'd2): begin
                    h1 = 4'd1;
                    h0 = h0_q - 4'd2;
                end
                default: ;
            endcase
        end
    end

    assign m1        = m1_q;
    assign m0        = m0_q;
    assign s1        = s1_q;
    assign s0        = s0_q;
    assign pm        = (h1_q == 4'd2) || ((h1_q == 4'd1) && (h0_q >= 4'd2));
    assign tick_1hz  = tick_q;
    assign min_tick  = min_q;
    assign hour_tick = hour_q;
    assign day_tick  = day_q;
    assign load_err  = err_q;

endmodule
